// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial carry-lookahead adder.
package cla_pkg;

    // Width of the single carry-lookahead slice that is time-shared across lanes.
    localparam int SLICE_W = 8;

    // Controller states: waiting for operands, stepping slices, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of byte lanes processed for an operand of the given width.
    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
// Every internal carry is a flat sum-of-products of generate/propagate terms
// and the slice carry-in, so no carry ripples from bit to bit.
module cla8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;

    // Expand each carry c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b1;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc      = acc | (pp & cin);
            c[i + 1] = acc;
        end
    end

    assign s    = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 8-bit CLA
// slice. Bytes are processed least-significant first; the carry between
// slices lives in carry_q. Each slice is held on the CLA inputs for SETTLE
// cycles before its sum and carry are captured.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   slice_idx_q, slice_idx_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_eff_q, b_eff_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // The only CLA in the design; its inputs come from the byte mux below.
    cla8_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // Byte mux: select lane slice_idx of the latched operands.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (slice_idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_eff_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    // Next-state logic: operand latch, settle countdown, slice capture and handshakes.
    always_comb begin
        state_d      = state_q;
        slice_idx_d  = slice_idx_q;
        settle_cnt_d = settle_cnt_q;
        a_d          = a_q;
        b_eff_d      = b_eff_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                    a_d          = a;
                    b_eff_d      = sub ? ~b : b;
                    carry_d      = sub ? 1'b1 : cin;
                    slice_idx_d  = '0;
                    settle_cnt_d = CNT_LOAD;
                    state_d      = RUN;
                end
            end

            RUN: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end else begin
                    // Last settle cycle of this slice: capture its sum byte and carry.
                    for (int i = 0; i < NSLICE; i++) begin
                        if (slice_idx_q == IDX_W'(i)) begin
                            sum_d[i*SLICE_W +: SLICE_W] = slice_s;
                        end
                    end
                    carry_d = slice_co;
                    if (slice_idx_q == LAST_IDX) begin
                        // slice_s[MSB] is the result sign bit at the final capture.
                        ovf_d   = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) &&
                                  (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                        state_d = DONE;
                    end else begin
                        slice_idx_d  = slice_idx_q + 1'b1;
                        settle_cnt_d = CNT_LOAD;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible result state; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slice_idx_q  <= '0;
            settle_cnt_q <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slice_idx_q  <= slice_idx_d;
            settle_cnt_q <= settle_cnt_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
        end
    end

    // Operand registers; only meaningful after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_eff_q <= b_eff_d;
    end

    // Ready is suppressed while reset is asserted so nothing is offered during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign overflow  = ovf_q;

endmodule
